// File: rtl/servant_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the servant Wishbone arbiter.
package servant_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_RDT = 32'hDEAD_BEEF;
    localparam int          MAX_M       = 4;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back. Only the low n bits take part.
    function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                                 input logic [1:0]       ptr,
                                                 input int unsigned      n);
        logic [MAX_M-1:0] rot;
        logic [MAX_M-1:0] gnt;
        logic [1:0]       idx;
        logic             found;
        int unsigned      k;
        rot   = '0;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < MAX_M; i++) begin
            if (i < n) begin
                idx    = 2'((i + ptr) % n);
                rot[i] = req[idx];
            end
        end
        for (int unsigned i = 0; i < MAX_M; i++) begin
            if (i < n && !found && rot[i]) begin
                found = 1'b1;
                k     = i;
            end
        end
        if (found) begin
            idx      = 2'((k + ptr) % n);
            gnt[idx] = 1'b1;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/servant_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first requester at or above i_ptr, wrapping.
module servant_rr_pick
    import servant_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int PW    = 1
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [NUM_M-1:0] o_gnt
);

    assign o_gnt = NUM_M'(rr_pick(MAX_M'(i_req), 2'(i_ptr), NUM_M));

endmodule

// File: rtl/servant_wb_rr_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave port between NUM_M masters.
// Optional forced termination of stalled transfers: define SERVANT_ARB_TIMEOUT_EN.
module servant_wb_rr_arbiter
    import servant_arb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic [NUM_M-1:0]    i_m_cyc,
    input  logic [NUM_M-1:0]    i_m_we,
    input  logic [NUM_M*AW-1:0] i_m_adr,
    input  logic [NUM_M*32-1:0] i_m_dat,
    input  logic [NUM_M*4-1:0]  i_m_sel,
    output logic [31:0]         o_m_rdt,
    output logic [NUM_M-1:0]    o_m_ack,
    output logic                o_s_cyc,
    output logic                o_s_we,
    output logic [AW-1:0]       o_s_adr,
    output logic [31:0]         o_s_dat,
    output logic [3:0]          o_s_sel,
    input  logic [31:0]         i_s_rdt,
    input  logic                i_s_ack,
    output logic [NUM_M-1:0]    o_grant,
    output logic                o_timeout
);

    localparam int PW = (NUM_M > 2) ? 2 : 1;

    if (NUM_M < 2 || NUM_M > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("servant_wb_rr_arbiter: NUM_M or TIMEOUT out of range");
    end

    arb_state_e       r_state;
    logic [NUM_M-1:0] r_grant;
    logic [PW-1:0]    r_ptr;
    logic [NUM_M-1:0] w_pick;
    logic [PW-1:0]    w_gidx;
    logic [PW-1:0]    w_next_ptr;
    logic             w_busy;
    logic             w_req_live;
    logic             w_ack;
    logic             w_tmo;

    servant_rr_pick #(.NUM_M(NUM_M), .PW(PW)) u_pick (
        .i_req (i_m_cyc),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_grant[i]) w_gidx = PW'(i);
        end
    end

    assign w_next_ptr = (w_gidx == PW'(NUM_M - 1)) ? '0 : w_gidx + 1'b1;
    assign w_busy     = (r_state == BUSY);
    // Granted master still holding cyc; dropping it aborts the transfer without an ack.
    assign w_req_live = w_busy & |(i_m_cyc & r_grant);
    assign w_ack      = w_req_live & i_s_ack;

`ifdef SERVANT_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_timeout;

    // r_cnt counts stalled BUSY cycles before this one, so the match lands on stalled cycle TIMEOUT.
    assign w_tmo     = w_req_live & ~i_s_ack & (r_cnt == 8'(TIMEOUT - 1));
    assign o_timeout = r_timeout;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_busy)       r_cnt <= '0;
            else if (!i_s_ack) r_cnt <= r_cnt + 8'd1;
            if (w_tmo)         r_timeout <= 1'b1;
        end
    end
`else
    assign w_tmo     = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|i_m_cyc) begin
                        r_state <= BUSY;
                        r_grant <= w_pick;
                    end
                end
                BUSY: begin
                    if (w_ack || w_tmo || !w_req_live) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Grant is zero while idle, so the one-hot mux drives all slave fields to zero then.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_s_we  = 1'b0;
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_grant[i]) begin
                o_s_we  = i_m_we[i];
                o_s_adr = i_m_adr[i*AW +: AW];
                o_s_dat = i_m_dat[i*32 +: 32];
                o_s_sel = i_m_sel[i*4 +: 4];
            end
        end
    end

    assign o_s_cyc = w_req_live & ~w_tmo;
    assign o_m_ack = (w_ack || w_tmo) ? r_grant : '0;
    assign o_m_rdt = w_tmo ? TIMEOUT_RDT : i_s_rdt;
    assign o_grant = r_grant;

endmodule

// File: tb/tb_servant_wb_rr_arbiter.sv
// Scoreboard bench for servant_wb_rr_arbiter; the timeout scenario follows SERVANT_ARB_TIMEOUT_EN.
module tb_servant_wb_rr_arbiter;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [1:0]  i_m_cyc;
    logic [1:0]  i_m_we;
    logic [63:0] i_m_adr;
    logic [63:0] i_m_dat;
    logic [7:0]  i_m_sel;
    logic [31:0] o_m_rdt;
    logic [1:0]  o_m_ack;
    logic        o_s_cyc;
    logic        o_s_we;
    logic [31:0] o_s_adr;
    logic [31:0] o_s_dat;
    logic [3:0]  o_s_sel;
    logic [31:0] i_s_rdt;
    logic        i_s_ack;
    logic [1:0]  o_grant;
    logic        o_timeout;

    typedef struct packed {
        logic [1:0]  ack;
        logic [31:0] rdt;
    } resp_t;

    resp_t exp_q[$];
    int    total  = 0;
    int    bad    = 0;
    int    n_acks = 0;

    servant_wb_rr_arbiter #(.NUM_M(2), .AW(32), .TIMEOUT(8)) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .i_m_cyc   (i_m_cyc),
        .i_m_we    (i_m_we),
        .i_m_adr   (i_m_adr),
        .i_m_dat   (i_m_dat),
        .i_m_sel   (i_m_sel),
        .o_m_rdt   (o_m_rdt),
        .o_m_ack   (o_m_ack),
        .o_s_cyc   (o_s_cyc),
        .o_s_we    (o_s_we),
        .o_s_adr   (o_s_adr),
        .o_s_dat   (o_s_dat),
        .o_s_sel   (o_s_sel),
        .i_s_rdt   (i_s_rdt),
        .i_s_ack   (i_s_ack),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    // Monitor: every master ack must match the next queued response.
    always @(negedge wb_clk) begin
        resp_t e;
        if (o_m_ack != 2'b00) begin
            n_acks++;
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(o_m_ack), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("ack_who", 32'(o_m_ack), 32'(e.ack));
                check("ack_rdt", o_m_rdt, e.rdt);
            end
        end
    end

    initial begin
        #100000;
        bad++;
        total++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        i_m_cyc = 2'b11;
        i_m_we  = 2'b00;
        i_m_adr = '0;
        i_m_dat = '0;
        i_m_sel = '0;
        i_s_ack = 1'b1;
        i_s_rdt = 32'h5555_5555;

        // Reset held with both masters requesting and a stray slave ack.
        repeat (3) tick();
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_s_cyc", 32'(o_s_cyc), 32'h0);
        check("rst_m_ack", 32'(o_m_ack), 32'h0);
        i_s_ack  = 1'b0;
        wb_rst_n = 1'b1;
        tick();
        check("rst_first_grant", 32'(o_grant), 32'h1);

        // Abort M0 so ptr moves to 1; ack while idle must be ignored.
        i_m_cyc = 2'b00;
        tick();
        check("abort0_idle", 32'(o_grant), 32'h0);
        i_s_ack = 1'b1;
        #1;
        check("idle_ack_ignored", 32'(o_m_ack), 32'h0);
        i_s_ack = 1'b0;

        // Single read from M1, slave acks two cycles after o_s_cyc.
        i_m_cyc = 2'b10;
        i_m_adr = {32'h0000_0100, 32'h0000_0444};
        tick();
        check("rd_grant", 32'(o_grant), 32'h2);
        check("rd_s_cyc", 32'(o_s_cyc), 32'h1);
        check("rd_adr_c1", o_s_adr, 32'h100);
        tick();
        check("rd_adr_c2", o_s_adr, 32'h100);
        check("rd_no_early_ack", 32'(o_m_ack), 32'h0);
        tick();
        exp_q.push_back('{ack: 2'b10, rdt: 32'h1234_5678});
        i_s_ack = 1'b1;
        i_s_rdt = 32'h1234_5678;
        #1;
        check("rd_adr_c3", o_s_adr, 32'h100);
        tick();
        i_s_ack = 1'b0;
        i_m_cyc = 2'b00;
        #1;
        check("rd_after_idle", 32'(o_grant), 32'h0);

        // Contention: both hold cyc, slave acks in the first BUSY cycle.
        n0 = n_acks;
        i_m_cyc = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                check("cont_grant", 32'(o_grant), (k % 4 == 0) ? 32'h1 : 32'h2);
                exp_q.push_back('{ack: (k % 4 == 0) ? 2'b01 : 2'b10, rdt: 32'hC0DE_0000 + 32'(k)});
                i_s_ack = 1'b1;
                i_s_rdt = 32'hC0DE_0000 + 32'(k);
            end else begin
                i_s_ack = 1'b0;
                check("cont_idle_gap", 32'(o_grant), 32'h0);
                if (k == 7) i_m_cyc = 2'b00;
            end
        end
        check("cont_ack_count", 32'(n_acks - n0), 32'd4);

        // Write mux: M0 wins (ptr=0), M1 presents conflicting values.
        tick();
        i_m_cyc = 2'b11;
        i_m_we  = 2'b01;
        i_m_adr = {32'h0000_0300, 32'h0000_0200};
        i_m_dat = {32'h1111_1111, 32'hCAFE_F00D};
        i_m_sel = {4'b1100, 4'b0011};
        #1;
        check("idle_s_dat_zero", o_s_dat, 32'h0);
        check("idle_s_adr_zero", o_s_adr, 32'h0);
        tick();
        check("wr_grant", 32'(o_grant), 32'h1);
        check("wr_we", 32'(o_s_we), 32'h1);
        check("wr_dat", o_s_dat, 32'hCAFE_F00D);
        check("wr_sel", 32'(o_s_sel), 32'h3);
        check("wr_adr", o_s_adr, 32'h200);
        exp_q.push_back('{ack: 2'b01, rdt: 32'h0});
        i_s_ack = 1'b1;
        i_s_rdt = 32'h0;
        tick();
        i_s_ack = 1'b0;
        i_m_cyc = 2'b00;
        #1;
        check("wr_idle_dat_zero", o_s_dat, 32'h0);
        check("wr_idle_we_zero", 32'(o_s_we), 32'h0);

        // Abort: M0 granted via wrap from ptr=1, then drops cyc before ack.
        i_m_we  = 2'b00;
        i_m_cyc = 2'b01;
        tick();
        check("ab_grant", 32'(o_grant), 32'h1);
        check("ab_s_cyc_up", 32'(o_s_cyc), 32'h1);
        i_m_cyc = 2'b00;
        #1;
        check("ab_s_cyc_fall", 32'(o_s_cyc), 32'h0);
        check("ab_no_ack", 32'(o_m_ack), 32'h0);
        tick();
        check("ab_idle", 32'(o_grant), 32'h0);
        i_m_cyc = 2'b11;
        tick();
        check("ab_next_m1", 32'(o_grant), 32'h2);
        exp_q.push_back('{ack: 2'b10, rdt: 32'hA5A5_A5A5});
        i_s_ack = 1'b1;
        i_s_rdt = 32'hA5A5_A5A5;
        tick();
        i_s_ack = 1'b0;
        i_m_cyc = 2'b00;

        // Stalled slave: M0 granted and never acked.
        i_s_rdt = 32'h1111_2222;
        i_m_cyc = 2'b01;
        tick();
        check("to_grant", 32'(o_grant), 32'h1);
`ifdef SERVANT_ARB_TIMEOUT_EN
        exp_q.push_back('{ack: 2'b01, rdt: 32'hDEAD_BEEF});
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            if (c < 8) begin
                check("to_wait_no_ack", 32'(o_m_ack), 32'h0);
            end else begin
                check("to_forced_ack", 32'(o_m_ack), 32'h1);
                check("to_forced_rdt", o_m_rdt, 32'hDEAD_BEEF);
                check("to_s_cyc_low", 32'(o_s_cyc), 32'h0);
            end
            if (c == 7) check("to_flag_pre", 32'(o_timeout), 32'h0);
        end
        tick();
        check("to_idle", 32'(o_grant), 32'h0);
        check("to_flag_set", 32'(o_timeout), 32'h1);
        i_m_cyc = 2'b00;
        repeat (3) tick();
        check("to_flag_sticky", 32'(o_timeout), 32'h1);
`else
        n0 = n_acks;
        repeat (300) tick();
        check("nto_grant_held", 32'(o_grant), 32'h1);
        check("nto_s_cyc", 32'(o_s_cyc), 32'h1);
        check("nto_no_ack", 32'(n_acks - n0), 32'd0);
        check("nto_flag_zero", 32'(o_timeout), 32'h0);
        i_m_cyc = 2'b00;
        tick();
`endif

        // Reset mid-transfer with an ack pending: everything clears at once.
        i_m_cyc = 2'b11;
        tick();
        check("mr_grant", 32'(o_grant), 32'h2);
        i_s_ack  = 1'b1;
        wb_rst_n = 1'b0;
        #1;
        check("mr_grant_clear", 32'(o_grant), 32'h0);
        check("mr_s_cyc_clear", 32'(o_s_cyc), 32'h0);
        check("mr_no_ack", 32'(o_m_ack), 32'h0);
        check("mr_flag_clear", 32'(o_timeout), 32'h0);
        tick();
        i_s_ack  = 1'b0;
        i_m_cyc  = 2'b00;
        wb_rst_n = 1'b1;
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
